// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dataA;
  logic [XLEN-1:0] dataB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, dataA, dataB,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, dataA, dataB,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, 32 iterations, then a sign/special-case fixup.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]      op_p0;
  logic [XLEN-1:0] a_raw_p0;
  logic [XLEN-1:0] b_raw_p0;
  logic [XLEN-1:0] opd_p0;
  logic            neg_p0;

  logic [XLEN-1:0] hi_p1;
  logic [XLEN-1:0] lo_p1;
  logic [4:0]      cnt_p1;

  logic            done_p2;
  logic [XLEN-1:0] result_p2;

  function automatic logic [XLEN-1:0] cneg32(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg64(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic            is_div;
  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic            neg_in;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    is_div = bus.funct3[2];
    a_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
             (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
             (bus.funct3 == 3'b110);
    a_neg  = a_sgn & bus.dataA[XLEN-1];
    b_neg  = b_sgn & bus.dataB[XLEN-1];
    a_mag  = cneg32(bus.dataA, a_neg);
    b_mag  = cneg32(bus.dataB, b_neg);
    // Remainder follows the dividend; product and quotient follow the sign XOR.
    neg_in = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_trial;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, opd_p0} : {(XLEN+1){1'b0}});
    div_trial = {hi_p1, lo_p1[XLEN-1]};
    div_diff  = div_trial - {1'b0, opd_p0};
  end

  logic [2*XLEN-1:0] prod_c;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   result_fix;

  always_comb begin
    prod_c   = cneg64({hi_p1, lo_p1}, neg_p0);
    div_zero = (b_raw_p0 == {XLEN{1'b0}});
    div_ovf  = (a_raw_p0 == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw_p0 == {XLEN{1'b1}});
    result_fix = {XLEN{1'b0}};
    case (op_p0)
      3'b000:  result_fix = prod_c[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  result_fix = prod_c[2*XLEN-1:XLEN];
      3'b100: begin
        if (div_zero)     result_fix = {XLEN{1'b1}};
        else if (div_ovf) result_fix = {1'b1, {(XLEN-1){1'b0}}};
        else              result_fix = cneg32(lo_p1, neg_p0);
      end
      3'b101:  result_fix = div_zero ? {XLEN{1'b1}} : lo_p1;
      3'b110: begin
        if (div_zero)     result_fix = a_raw_p0;
        else if (div_ovf) result_fix = {XLEN{1'b0}};
        else              result_fix = cneg32(hi_p1, neg_p0);
      end
      default: result_fix = div_zero ? a_raw_p0 : hi_p1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt_p1 == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0    <= 3'b000;
      a_raw_p0 <= {XLEN{1'b0}};
      b_raw_p0 <= {XLEN{1'b0}};
      opd_p0   <= {XLEN{1'b0}};
      neg_p0   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      op_p0    <= bus.funct3;
      a_raw_p0 <= bus.dataA;
      b_raw_p0 <= bus.dataB;
      opd_p0   <= is_div ? b_mag : a_mag;
      neg_p0   <= neg_in;
    end
  end

  // Stage p1: one multiply or divide iteration per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_p1  <= {XLEN{1'b0}};
      lo_p1  <= {XLEN{1'b0}};
      cnt_p1 <= 5'd0;
    end else if (state == IDLE && bus.start) begin
      hi_p1  <= {XLEN{1'b0}};
      lo_p1  <= is_div ? a_mag : b_mag;
      cnt_p1 <= 5'd0;
    end else if (state == CALC) begin
      cnt_p1 <= cnt_p1 + 5'd1;
      if (op_p0[2]) begin
        if (!div_diff[XLEN]) begin
          hi_p1 <= div_diff[XLEN-1:0];
          lo_p1 <= {lo_p1[XLEN-2:0], 1'b1};
        end else begin
          hi_p1 <= div_trial[XLEN-1:0];
          lo_p1 <= {lo_p1[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_p1 <= mul_sum[XLEN:1];
        lo_p1 <= {mul_sum[0], lo_p1[XLEN-1:1]};
      end
    end
  end

  // Stage p2: sign correction, word select, completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_p2   <= 1'b0;
      result_p2 <= {XLEN{1'b0}};
    end else begin
      done_p2 <= (state == FIX);
      if (state == FIX) result_p2 <= result_fix;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_p2;
  assign bus.result = result_p2;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    int          ia = a;
    int          ib = b;
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op, scrambles inputs after acceptance, waits up to 40 cycles.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
    lat    = -1;
    busy_n = 0;
    res    = 32'hx;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d actual=no-done required=done", f);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    int          lat;
    int          busy_n;
    int          dones;
    int          busy_seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulh_min_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{"mulhu_max_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{"mulhsu_m1_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{"divu_5_0",      3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{"remu_5_0",      3'd7, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{"div_m7_0",      3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[13] = '{"rem_m7_0",      3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.dataA  = 32'd0;
    bus.dataB  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   {31'b0, bus.busy}, 32'd0);
    chk("reset_done",   {31'b0, bus.done}, 32'd0);
    chk("reset_result", bus.result,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busy_n);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat, 33);
      chk({vecs[i].name, "_busy_cycles"}, busy_n, 33);
    end

    // Start pulse while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.dataA = 32'd3; bus.dataB = 32'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    lat   = -1;
    res   = 32'hx;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) begin
        bus.start = 1'b1; bus.dataA = 32'd5; bus.dataB = 32'd6;
      end
      if (k == 11) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          res = bus.result;
        end
      end
    end
    chk("ignore_result",  res,   32'd12);
    chk("ignore_latency", lat,   33);
    chk("ignore_dones",   dones, 1);
    chk("ignore_idle",    {31'b0, bus.busy}, 32'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.dataA = 32'd1000; bus.dataB = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy",   {31'b0, bus.busy}, 32'd0);
    chk("abort_done",   {31'b0, bus.done}, 32'd0);
    chk("abort_result", bus.result,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones     = 0;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (bus.busy) busy_seen++;
    end
    chk("abort_no_done", dones,     0);
    chk("abort_no_busy", busy_seen, 0);
    run_op(3'd0, 32'd6, 32'd7, res, lat, busy_n);
    chk("after_abort_mul", res, 32'd42);
    chk("after_abort_lat", lat, 33);

    // Randomized back-to-back ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op(rf, ra, rb, res, lat, busy_n);
      chk($sformatf("rand%0d_op%0d_%h_%h", n, rf, ra, rb), res, model(rf, ra, rb));
      chk($sformatf("rand%0d_latency", n), lat, 33);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the ALU operand pair: dataA from rs1 and dataB from the operand-B select path.
- Returns a 32-bit result after a fixed multi-cycle latency.
- Sits beside the ALU in the execute stage. The pipeline stalls on busy and captures result on done.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
dataA  input  XLEN  operand A (rs1)
dataB  input  XLEN  operand B (rs2)
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; held until next completion

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, result=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation: no done pulse, result=0.
- States and transitions:
  - IDLE -> CALC on start=1.
  - CALC -> FIX after the 32nd iteration.
  - FIX -> IDLE unconditionally.
- Acceptance (IDLE, start=1 at edge E0):
  - Latch funct3, dataA, dataB.
  - Compute operand magnitudes and result sign (see signedness).
  - Clear the accumulator, iteration counter = 0.
  - busy=1 from E0.
- CALC, edges E1..E32: one iteration per cycle; 5-bit counter; leave CALC when counter = 31.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract, one quotient bit per cycle, 32-bit remainder.
- FIX (edge E33):
  - Apply sign correction.
  - Select the low/high product word, quotient, or remainder into result.
  - done=1 for exactly the cycle after E33; busy=0 from E33.
- Latency: 33 cycles from start edge to done, identical for all ops including special cases.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low 32 bits, sign-independent.
  - DIV: quotient negative iff signs differ.
  - REM: remainder takes the dividend's sign.
- Special cases (resolved in FIX; divisor tested on the latched value):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- start while busy=1 is ignored; operands are not re-latched.
- start in the same cycle done=1 (state IDLE) is accepted; back-to-back throughput is one op per 34 cycles.
- Input changes after acceptance have no effect.
- result changes only at FIX or reset.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB. done exactly 33 cycles after start; busy high for those 33 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. All with 33-cycle latency.
- Pulse start with new operands at cycle 10 of a busy MUL 3 × 4 -> second request ignored; result 12; only one done pulse.
- Assert rst at cycle 15 of a DIV -> busy=0, done=0, result=0 immediately; no done afterwards. A new MUL 6 × 7 after release -> 42.
